pin_sample_scheduler: RTL and testbench
=======================================

# pin_sample_scheduler

Periodic sampling scheduler for the pin controller array. Every `sample_period` clocks it sweeps the enabled pins in ascending order. For each pin it requests the shared register bus, reads that controller's sample register, and pushes a tagged sample word into an internal FIFO that the host drains. It sits between the host bus arbiter and the pin controllers, replacing host-driven polling.

## Interface
Parameters:
- `NUM_PINS`, 8: number of pin controllers; pin i lives at base address i<<8. Legal range 1..256.
- `FIFO_DEPTH`, 16: sample FIFO entries; power of two, at least 2.
- `SAMPLE_OFFSET`, 7: register offset of the sample register within a pin's 256-word window.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 enables periodic sweeps.
- `sample_period`  in  16  clocks between sweep starts; 0 is treated as 1.
- `pin_mask`  in  NUM_PINS  1 = pin included in the sweep.
- `clear`  in  1  one-cycle pulse; flushes the FIFO and clears the `overflow` and `overrun` flags.
- `bus_req`  out  1  request to the host bus arbiter.
- `bus_gnt`  in  1  grant from the arbiter; the scheduler may drive the bus only while `bus_gnt` = 1.
- `addr`  out  21  bus address; 0 when not granted.
- `data_rd`  out  1  bus read strobe.
- `data_in`  in  16  bus read data, valid combinationally while `data_rd` = 1.
- `fifo_rd`  in  1  host pop strobe; ignored when the FIFO is empty.
- `fifo_data`  out  FW  head word, where FW = 16, or 32 with SCHED_TIMESTAMP_EN.
- `fifo_empty`  out  1
- `fifo_count`  out  clog2(FIFO_DEPTH)+1
- `overflow`  out  1  sticky; set when a sample was dropped because the FIFO was full.
- `overrun`  out  1  sticky; set when a tick arrived while a sweep was still active.

## Operation
- Period counter: reloads with max(`sample_period`, 1) on each tick and decrements every clock while `run` = 1.
  - A tick fires when the counter equals 1.
  - When `run` = 0 the counter holds at its reload value and no ticks fire.
- FSM states:
  - IDLE: wait for a tick. On a tick with `pin_mask` ≠ 0, latch the mask, set the pin index to the lowest set bit, and go to REQ. On a tick with `pin_mask` = 0, stay in IDLE.
  - REQ: assert `bus_req`. When `bus_gnt` = 1, go to READ.
  - READ: hold `bus_req`, drive `addr` = (pin<<8) + SAMPLE_OFFSET, and assert `data_rd`. Capture `data_in` at the closing clock edge, then go to PUSH.
  - PUSH: deassert `bus_req`. Write the sample word to the FIFO, or drop it and set `overflow` if the FIFO is full. If a higher latched mask bit remains, advance to it and go to REQ; otherwise go to IDLE.
- If `bus_gnt` drops during READ, discard the capture and return to REQ for the same pin.
- Sample word [15:0]:
  - [15:8] pin index.
  - [7:1] sweep number mod 128; the counter increments at each sweep start.
  - [0] = `data_in`[0].
- A tick while the FSM is not in IDLE sets `overrun`. The tick is not queued; the period counter still reloads.
- Dropping `run` mid-sweep lets the current sweep finish. Only new ticks are suppressed.
- Simultaneous push and pop on a full FIFO is accepted: no drop, count unchanged.
- Simultaneous push and pop on an empty FIFO: the push succeeds and the pop is ignored.
- `clear` has priority over both push and pop in the same cycle.
- Reset values: FSM IDLE, `bus_req` 0, `addr` 0, `data_rd` 0, `fifo_empty` 1, `fifo_count` 0, `fifo_data` 0, `overflow` 0, `overrun` 0, sweep number 0, period counter 1.

## Timing
- First tick comes 1 clock after `run` rises when the period counter is at its reset value. Subsequent ticks come every max(`sample_period`, 1) clocks.
- Per pin with immediate grant: tick → REQ (+1) → READ (+2) → PUSH (+3). The word is visible at the FIFO head 1 clock after PUSH when the FIFO was empty.
- A full sweep of k pins with immediate grant takes 3k clocks. Any `sample_period` below 3k + 1 guarantees `overrun`.
- `fifo_data` is registered and valid whenever `fifo_empty` = 0. A pop advances the head on the next clock edge.
- `overflow` and `overrun` set on the clock edge after the triggering event.

## Configuration
- `SCHED_TIMESTAMP_EN` defined:
  - A 16-bit free-running timestamp counter is compiled in; it resets to 0 and increments every clock.
  - FW = 32, with word [31:16] = timestamp value in the PUSH cycle.
- `SCHED_TIMESTAMP_EN` undefined: FW = 16; no timestamp counter is present.

## Test plan
- Single pin: `pin_mask` = 8'h04, `sample_period` = 20, `run` = 1, grant tied high, `data_in` = 1 → every 20 clocks one word 16'h0201, 0x0203, … ([7:1] increments); `addr` = 21'h000207 during READ.
- Mask sweep order: `pin_mask` = 8'hA1, grant tied high → pins 0, 5, 7 are read in that order within 9 clocks; pin indices appear in [15:8].
- Grant stall/drop: hold `bus_gnt` = 0 for 10 clocks in REQ, then pulse it for 1 clock during READ → no data_rd outside grant; the same pin is retried; exactly one word is pushed.
- FIFO full: FIFO_DEPTH = 4, no pops, 6 single-pin sweeps → `fifo_count` = 4 and `overflow` = 1; `clear` → count 0 and flag 0.
- Overrun: 8 pins enabled, `sample_period` = 10 → `overrun` = 1 after the first sweep; sweeps still complete with 8 words each.
- Reset mid-READ: assert `reset` low → `bus_req`, `data_rd` and `addr` go to 0 asynchronously; FIFO is empty; the FSM is IDLE when reset is released.

Source files
------------

// File: rtl/pin_sample_scheduler.sv
// pin_sample_scheduler: periodic sweep of enabled pin controllers into a host-drained sample FIFO
// Ports: clk/reset (async, active-low); run, sample_period, pin_mask, clear control the sweeps;
// bus_req/bus_gnt/addr/data_rd/data_in form the shared register-bus read path;
// fifo_rd/fifo_data/fifo_empty/fifo_count are the host FIFO side; overflow/overrun are sticky flags.
// Define SCHED_TIMESTAMP_EN to widen FIFO words to 32 bits with a free-running timestamp in [31:16].
module pin_sample_scheduler #(
    parameter int NUM_PINS      = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int SAMPLE_OFFSET = 7,
`ifdef SCHED_TIMESTAMP_EN
    localparam int FW = 32,
`else
    localparam int FW = 16,
`endif
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [15:0]         sample_period,
    input  logic [NUM_PINS-1:0] pin_mask,
    input  logic                clear,
    output logic                bus_req,
    input  logic                bus_gnt,
    output logic [20:0]         addr,
    output logic                data_rd,
    input  logic [15:0]         data_in,
    input  logic                fifo_rd,
    output logic [FW-1:0]       fifo_data,
    output logic                fifo_empty,
    output logic [AW:0]         fifo_count,
    output logic                overflow,
    output logic                overrun
);
    typedef enum logic [1:0] {IDLE, REQ, READ, PUSH} state_t;
    state_t state, state_nx;
    logic [15:0] period_cnt, reload;
    logic tick, sweep_start;
    logic [NUM_PINS-1:0] mask_q;
    logic [7:0] pin, first_pin, next_pin;
    logic has_next;
    logic [6:0] sweep_num;
    logic sample_bit;
    logic [FW-1:0] word;
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, do_push, do_pop, full;
    logic unused;

    assign unused = ^data_in[15:1];
    assign reload = (sample_period == 16'd0) ? 16'd1 : sample_period;
    assign tick = run && period_cnt == 16'd1;
    assign sweep_start = state == IDLE && tick && |pin_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) period_cnt <= 16'd1;
        else period_cnt <= (!run || tick) ? reload : period_cnt - 16'd1;
    end

    // Lowest set bit of the live mask for sweep start, and lowest latched bit above the current pin.
    always_comb begin
        first_pin = '0;
        next_pin = pin;
        has_next = 1'b0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (pin_mask[i]) first_pin = 8'(i);
            if (mask_q[i] && i > int'(pin)) begin
                has_next = 1'b1;
                next_pin = 8'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus_req = 1'b0;
        data_rd = 1'b0;
        addr = '0;
        unique case (state)
            IDLE: state_nx = sweep_start ? REQ : IDLE;
            REQ: begin
                bus_req = 1'b1;
                state_nx = bus_gnt ? READ : REQ;
            end
            READ: begin
                bus_req = 1'b1;
                data_rd = bus_gnt;
                addr = bus_gnt ? (21'(pin) << 8) + 21'(SAMPLE_OFFSET) : '0;
                state_nx = bus_gnt ? PUSH : REQ;
            end
            PUSH: state_nx = has_next ? REQ : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            pin <= '0;
            sweep_num <= '0;
            sample_bit <= 1'b0;
        end else begin
            if (sweep_start) begin
                mask_q <= pin_mask;
                pin <= first_pin;
                sweep_num <= sweep_num + 7'd1;
            end
            if (state == READ && bus_gnt) sample_bit <= data_in[0];
            if (state == PUSH && has_next) pin <= next_pin;
        end
    end

    // sweep_num already counts the running sweep, so the word carries the pre-increment value.
`ifdef SCHED_TIMESTAMP_EN
    logic [15:0] ts;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts <= '0;
        else ts <= ts + 16'd1;
    end
    assign word = {ts, pin, sweep_num - 7'd1, sample_bit};
`else
    assign word = {pin, sweep_num - 7'd1, sample_bit};
`endif

    assign push = state == PUSH;
    assign full = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign do_pop = fifo_rd && fifo_count != '0;
    assign do_push = push && (!full || do_pop);
    assign fifo_empty = fifo_count == '0;
    assign fifo_data = fifo_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
            overrun <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            overflow <= overflow | (push && !do_push);
            overrun <= overrun | (tick && state != IDLE);
        end
    end
endmodule

// File: tb/tb_pin_sample_scheduler.sv
// tb_pin_sample_scheduler: directed and randomized checks of pin_sample_scheduler against a sweep-level model
module tb_pin_sample_scheduler;
    localparam int NP = 8;
    localparam int DEPTH = 4;
`ifdef SCHED_TIMESTAMP_EN
    localparam int FW = 32;
`else
    localparam int FW = 16;
`endif
    logic clk = 1'b0, reset = 1'b0, run = 1'b0, clear = 1'b0, bus_gnt = 1'b0, fifo_rd = 1'b0;
    logic [15:0] sample_period = 16'd20;
    logic [NP-1:0] pin_mask = '0;
    logic [15:0] data_in;
    logic bus_req, data_rd, fifo_empty, overflow, overrun;
    logic [20:0] addr;
    logic [FW-1:0] fifo_data;
    logic [2:0] fifo_count;
    logic [NP-1:0] pin_val = '0;
    logic [14:0] noise = '0;
    int errors = 0, checks = 0, cyc = 0, sw = 0;
    bit auto_pop = 0, rand_gnt = 0;
    logic [15:0] exp_q[$];

    pin_sample_scheduler #(.NUM_PINS(NP), .FIFO_DEPTH(DEPTH), .SAMPLE_OFFSET(7)) dut (
        .clk(clk), .reset(reset), .run(run), .sample_period(sample_period), .pin_mask(pin_mask),
        .clear(clear), .bus_req(bus_req), .bus_gnt(bus_gnt), .addr(addr), .data_rd(data_rd),
        .data_in(data_in), .fifo_rd(fifo_rd), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .overflow(overflow), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pin controllers: only the sample register of an existing pin returns the true bit.
    always_comb data_in = {noise, pin_val[addr[10:8]] ^ (addr[7:0] != 8'd7 || addr[20:11] != 10'd0)};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (data_rd) chk("rd_without_gnt", 32'(bus_gnt), 1);
        if (!bus_gnt) chk("addr_when_ungranted", 32'(addr), 0);
        if (data_rd && bus_gnt) chk("read_offset", 32'(addr[7:0]), 7);
        fifo_rd = 1'b0;
        if (auto_pop && !fifo_empty) begin
            if (exp_q.size() == 0) chk("unexpected_word", 32'(exp_q.size()), 1);
            else chk("word", 32'(fifo_data[15:0]), 32'(exp_q.pop_front()));
            fifo_rd = 1'b1;
        end
        if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
        noise = 15'($urandom);
    endtask

    task automatic add_sweep(input logic [NP-1:0] m);
        if (m != '0) begin
            for (int i = 0; i < NP; i++)
                if (m[i]) exp_q.push_back({8'(i), 7'(sw), pin_val[i]});
            sw++;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !fifo_empty || bus_req) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 1);
    endtask

    task automatic pulse_run();
        run = 1'b1;
        step();
        run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t[4];
        int nt = 0;
        int rel;
        logic [2:0] pc = '0;
        run = 1'b1;
        pin_mask = 8'h04;
        pin_val[2] = 1'b1;
        bus_gnt = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_data_rd", 32'(data_rd), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_fifo_empty", 32'(fifo_empty), 1);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_fifo_data", 32'(fifo_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b1;
        rel = cyc;
        repeat (66) begin
            step();
            if (data_rd) chk("single_pin_addr", 32'(addr), 32'h000207);
            if (fifo_count != pc && nt < 4) begin
                t[nt] = cyc;
                nt++;
                pc = fifo_count;
            end
        end
        run = 1'b0;
        chk("tick_count", 32'(nt), 4);
        chk("first_push_latency", 32'(t[0] - rel), 4);
        for (int k = 1; k < 4; k++) chk("period_spacing", 32'(t[k] - t[k-1]), 20);
        chk("p1_count", 32'(fifo_count), 4);
        chk("p1_overflow", 32'(overflow), 0);
        chk("p1_overrun", 32'(overrun), 0);
        repeat (4) add_sweep(8'h04);
        auto_pop = 1;
        drain(50);
        auto_pop = 0;
        sample_period = 16'd1;
        repeat (2) step();
        repeat (6) begin
            pulse_run();
            repeat (5) step();
        end
        chk("full_count", 32'(fifo_count), 4);
        chk("full_overflow", 32'(overflow), 1);
        chk("full_overrun", 32'(overrun), 0);
        chk("full_head", 32'(fifo_data[15:0]), 32'({8'd2, 7'(sw), 1'b1}));
        sw += 6;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_count", 32'(fifo_count), 0);
        chk("clear_overflow", 32'(overflow), 0);
        chk("clear_empty", 32'(fifo_empty), 1);
        chk("clear_data", 32'(fifo_data), 0);
        auto_pop = 1;
        rand_gnt = 1;
        for (int it = 0; it < 24; it++) begin
            pin_mask = (it == 0) ? 8'hA1 : 8'($urandom);
            pin_val = 8'($urandom);
            add_sweep(pin_mask);
            pulse_run();
            drain(400);
        end
        rand_gnt = 0;
        bus_gnt = 1'b1;
        chk("rand_overflow", 32'(overflow), 0);
        chk("rand_overrun", 32'(overrun), 0);
        pin_mask = 8'hFF;
        pin_val = 8'($urandom);
        sample_period = 16'd10;
        repeat (2) step();
        add_sweep(8'hFF);
        add_sweep(8'hFF);
        run = 1'b1;
        repeat (55) step();
        run = 1'b0;
        drain(200);
        chk("overrun_set", 32'(overrun), 1);
        chk("overrun_no_overflow", 32'(overflow), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("overrun_cleared", 32'(overrun), 0);
        sample_period = 16'd1;
        pin_mask = 8'h01;
        repeat (2) step();
        pulse_run();
        step();
        chk("midread_data_rd", 32'(data_rd), 1);
        chk("midread_addr", 32'(addr), 32'h000007);
        #1 reset = 1'b0;
        #1;
        chk("async_bus_req", 32'(bus_req), 0);
        chk("async_data_rd", 32'(data_rd), 0);
        chk("async_addr", 32'(addr), 0);
        chk("async_fifo_empty", 32'(fifo_empty), 1);
        step();
        reset = 1'b1;
        sw = 0;
        repeat (3) step();
        chk("post_rst_idle", 32'(bus_req), 0);
        chk("post_rst_empty", 32'(fifo_empty), 1);
        pin_val = 8'($urandom);
        add_sweep(8'h01);
        pulse_run();
        drain(100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
